v_elem_issue_seq: RTL and testbench

Element-group issue sequencer for the vector core control unit. Accepts one vector instruction at a time over a valid/ready handshake and drives the lane-validity tracker directly downstream of it. Its outputs are `load_o`, `shift_en_o`, `shift_partial_o` and a latched `vl_o`. It steps through `ceil(vl/VLANE_NUM)` element groups, plus `VLANE_NUM-1` partial-result shifts for reductions, honouring a downstream stall.

---
 rtl/v_elem_issue_seq.sv | 148 ++++++++++++++
 tb/tb_v_elem_issue_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/v_elem_issue_seq.sv
// v_elem_issue_seq
// Element-group issue sequencer for the vector core control unit. It takes one
// vector instruction at a time over a valid/ready handshake. It then pulses
// load_o once and issues ceil(vl/VLANE_NUM) element groups on shift_en_o.
// For reductions it follows with VLANE_NUM-1 partial-result shifts. A
// one-cycle done_o pulse ends the instruction. stall_i freezes the issue and
// partial phases.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous reset, active low
//   instr_valid_i    instruction offered
//   instr_ready_o    sequencer idle, will accept
//   vl_i             vector length of offered instruction
//   reduction_i      offered instruction is a reduction
//   stall_i          downstream backpressure (gates shift_en_o / shift_partial_o)
//   load_o           one-cycle load pulse to the validity tracker
//   vl_o             vl latched at accept, stable until the next accept
//   shift_en_o       issue one element group this cycle
//   shift_partial_o  advance partial-result validity by one lane
//   elem_idx_o       group index of the current shift_en_o
//   last_o           qualifies the final shift_en_o of the instruction
//   done_o           one-cycle pulse when the instruction is fully sequenced
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for an instruction; latch vl/reduction on accept
// LOAD    | load pulse, clear group and partial counters
// ISSUE   | one element group per unstalled cycle
// PARTIAL | VLANE_NUM-1 partial shifts (reductions only)
// DONE    | done pulse, back to IDLE

module v_elem_issue_seq #(
    parameter int  MAX_VL_PER_LANE = 256,
    parameter int  VLANE_NUM       = 8,
    localparam int VLW             = $clog2(VLANE_NUM*MAX_VL_PER_LANE),
    localparam int IW              = $clog2(MAX_VL_PER_LANE)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           instr_valid_i,
    output logic           instr_ready_o,
    input  logic [VLW-1:0] vl_i,
    input  logic           reduction_i,
    input  logic           stall_i,
    output logic           load_o,
    output logic [VLW-1:0] vl_o,
    output logic           shift_en_o,
    output logic           shift_partial_o,
    output logic [IW-1:0]  elem_idx_o,
    output logic           last_o,
    output logic           done_o
);

    localparam int GW = IW + 1;
    localparam int LW = $clog2(VLANE_NUM);
    localparam int PW = (LW < 1) ? 1 : LW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_PARTIAL,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [VLW-1:0] vl_q;
    logic           red_q;
    logic [GW-1:0]  groups_q;
    logic [IW-1:0]  elem_idx_q;
    logic [PW-1:0]  part_cnt_q;

    logic [GW-1:0]  groups_in;
    logic           is_last;
    logic           part_last;

    // Round up: a non-zero remainder in the low lane bits needs one more group.
    assign groups_in = GW'(vl_i >> LW) + GW'(vl_i[LW-1:0] != '0);

    // groups_q is at least 1 whenever ISSUE is entered, so the subtraction cannot wrap there.
    assign is_last   = ({1'b0, elem_idx_q} == (groups_q - GW'(1)));
    assign part_last = (part_cnt_q == PW'(VLANE_NUM - 2));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (instr_valid_i) state_d = S_LOAD;
            S_LOAD:    state_d = (groups_q == '0) ? S_DONE : S_ISSUE;
            S_ISSUE:   if (!stall_i && is_last) state_d = red_q ? S_PARTIAL : S_DONE;
            S_PARTIAL: if (!stall_i && part_last) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vl_q       <= '0;
            red_q      <= 1'b0;
            groups_q   <= '0;
            elem_idx_q <= '0;
            part_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid_i) begin
                        vl_q     <= vl_i;
                        red_q    <= reduction_i;
                        groups_q <= groups_in;
                    end
                end
                S_LOAD: begin
                    elem_idx_q <= '0;
                    part_cnt_q <= '0;
                end
                S_ISSUE: begin
                    // Index stays on the final group so it reads back as groups-1 afterwards.
                    if (!stall_i && !is_last) elem_idx_q <= elem_idx_q + 1'b1;
                end
                S_PARTIAL: begin
                    if (!stall_i) part_cnt_q <= part_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        instr_ready_o   = (state_q == S_IDLE);
        load_o          = (state_q == S_LOAD);
        shift_en_o      = (state_q == S_ISSUE) && !stall_i;
        shift_partial_o = (state_q == S_PARTIAL) && !stall_i;
        last_o          = (state_q == S_ISSUE) && !stall_i && is_last;
        done_o          = (state_q == S_DONE);
        vl_o            = vl_q;
        elem_idx_o      = elem_idx_q;
    end

endmodule

// File: tb/tb_v_elem_issue_seq.sv
// tb_v_elem_issue_seq
// Bench for v_elem_issue_seq. The stimulus process offers instructions and
// pushes the expected event stream into a queue: a load, then one shift per
// group carrying its index and last flag, then any partial shifts, then done.
// A negedge monitor pops that stream cycle by cycle. Load and done must appear
// regardless of stall_i. Shift and partial events must appear exactly on
// unstalled cycles. Nothing may appear while the queue is empty.

module tb_v_elem_issue_seq;

    localparam int MVL = 256;
    localparam int VLN = 8;
    localparam int VLW = $clog2(VLN*MVL);
    localparam int IW  = $clog2(MVL);

    localparam logic [3:0] K_LOAD  = 4'b1000;
    localparam logic [3:0] K_SHIFT = 4'b0100;
    localparam logic [3:0] K_PART  = 4'b0010;
    localparam logic [3:0] K_DONE  = 4'b0001;

    logic           clk_i;
    logic           rst_i;
    logic           instr_valid_i;
    logic           instr_ready_o;
    logic [VLW-1:0] vl_i;
    logic           reduction_i;
    logic           stall_i;
    logic           load_o;
    logic [VLW-1:0] vl_o;
    logic           shift_en_o;
    logic           shift_partial_o;
    logic [IW-1:0]  elem_idx_o;
    logic           last_o;
    logic           done_o;

    v_elem_issue_seq #(
        .MAX_VL_PER_LANE(MVL),
        .VLANE_NUM      (VLN)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_valid_i  (instr_valid_i),
        .instr_ready_o  (instr_ready_o),
        .vl_i           (vl_i),
        .reduction_i    (reduction_i),
        .stall_i        (stall_i),
        .load_o         (load_o),
        .vl_o           (vl_o),
        .shift_en_o     (shift_en_o),
        .shift_partial_o(shift_partial_o),
        .elem_idx_o     (elem_idx_o),
        .last_o         (last_o),
        .done_o         (done_o)
    );

    typedef struct packed {
        logic [3:0]    kind;
        logic [IW-1:0] idx;
        logic          last;
    } ev_t;

    ev_t            ev_q[$];
    ev_t            pend_q[$];
    bit             pend_valid;
    logic [VLW-1:0] pend_vl;
    logic [VLW-1:0] exp_vl;

    int n_chk  = 0;
    int n_pass = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference behaviour: groups is vl divided by the lane count, rounded up.
    task automatic model(input int vl, input bit red);
        int  groups;
        ev_t e;
        groups = (vl + VLN - 1) / VLN;
        pend_q.delete();
        e = '{kind: K_LOAD, idx: '0, last: 1'b0};
        pend_q.push_back(e);
        for (int g = 0; g < groups; g++) begin
            e = '{kind: K_SHIFT, idx: IW'(g), last: (g == groups - 1)};
            pend_q.push_back(e);
        end
        if (red && groups > 0) begin
            for (int p = 0; p < VLN - 1; p++) begin
                e = '{kind: K_PART, idx: '0, last: 1'b0};
                pend_q.push_back(e);
            end
        end
        e = '{kind: K_DONE, idx: '0, last: 1'b0};
        pend_q.push_back(e);
        pend_vl    = VLW'(vl);
        pend_valid = 1'b1;
    endtask

    always @(negedge clk_i) begin
        logic [3:0] obs;
        ev_t        f;
        if (rst_i) begin
            obs = {load_o, shift_en_o, shift_partial_o, done_o};
            chk("instr_ready", {31'b0, instr_ready_o}, {31'b0, ev_q.size() == 0});
            chk("vl_o", {21'b0, vl_o}, {21'b0, exp_vl});
            if (ev_q.size() == 0) begin
                chk("idle_outs", {28'b0, obs}, 32'd0);
                chk("idle_last", {31'b0, last_o}, 32'd0);
            end else begin
                f = ev_q[0];
                if (f.kind == K_LOAD || f.kind == K_DONE || !stall_i) begin
                    chk("event", {28'b0, obs}, {28'b0, f.kind});
                    if (f.kind == K_SHIFT) begin
                        chk("elem_idx", {24'b0, elem_idx_o}, {24'b0, f.idx});
                        chk("last", {31'b0, last_o}, {31'b0, f.last});
                    end else begin
                        chk("last_off", {31'b0, last_o}, 32'd0);
                    end
                    void'(ev_q.pop_front());
                end else begin
                    chk("stalled_outs", {28'b0, obs}, 32'd0);
                    chk("stalled_last", {31'b0, last_o}, 32'd0);
                end
            end
            if (pend_valid) begin
                foreach (pend_q[i]) ev_q.push_back(pend_q[i]);
                pend_q.delete();
                exp_vl     = pend_vl;
                pend_valid = 1'b0;
            end
        end
    end

    task automatic run(input int vl, input bit red, input int stall_pct, input bit keep_valid);
        bit acc = 1'b0;
        bit fin = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (acc && instr_ready_o) begin
                fin = 1'b1;
                break;
            end
            stall_i = ($urandom_range(99) < stall_pct);
            if (!acc) begin
                instr_valid_i = 1'b1;
                vl_i          = VLW'(vl);
                reduction_i   = red;
            end else if (keep_valid) begin
                vl_i        = VLW'($urandom);
                reduction_i = 1'($urandom_range(1));
            end else begin
                instr_valid_i = 1'b0;
            end
            if (!acc && instr_valid_i && instr_ready_o) begin
                model(vl, red);
                acc = 1'b1;
            end
            step();
        end
        instr_valid_i = 1'b0;
        stall_i       = 1'b0;
        chk("finish_in_budget", {31'b0, fin}, 32'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ready"}, {31'b0, instr_ready_o}, 32'd1);
        chk({tag, "_pulses"}, {27'b0, load_o, shift_en_o, shift_partial_o, last_o, done_o}, 32'd0);
        chk({tag, "_vl_o"}, {21'b0, vl_o}, 32'd0);
        chk({tag, "_elem_idx"}, {24'b0, elem_idx_o}, 32'd0);
    endtask

    task automatic reset_mid_op();
        int nsh = 0;
        bit hit = 1'b0;
        instr_valid_i = 1'b1;
        vl_i          = VLW'(40);
        reduction_i   = 1'b1;
        stall_i       = 1'b0;
        chk("rst_test_ready", {31'b0, instr_ready_o}, 32'd1);
        model(40, 1'b1);
        step();
        instr_valid_i = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (shift_en_o) nsh++;
            if (nsh == 3) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk("rst_reach_3rd_shift", {31'b0, hit}, 32'd1);
        #1;
        rst_i = 1'b0;
        ev_q.delete();
        pend_q.delete();
        pend_valid = 1'b0;
        exp_vl     = '0;
        #1;
        check_reset_outs("midrst");
        step();
        step();
        rst_i = 1'b1;
        step();
        step();
    endtask

    initial begin
        rst_i         = 1'b0;
        instr_valid_i = 1'b0;
        vl_i          = '0;
        reduction_i   = 1'b0;
        stall_i       = 1'b0;
        pend_valid    = 1'b0;
        pend_vl       = '0;
        exp_vl        = '0;
        #2;
        check_reset_outs("reset");
        step();
        step();
        rst_i = 1'b1;
        step();

        run(20, 1'b0, 0, 1'b0);
        run(8, 1'b1, 40, 1'b0);
        run(0, 1'b1, 30, 1'b0);
        run(2047, 1'b0, 0, 1'b0);
        run(2040, 1'b0, 10, 1'b0);
        run(33, 1'b0, 50, 1'b1);
        run(1, 1'b1, 0, 1'b1);
        run(VLN, 1'b0, 0, 1'b0);
        run(VLN + 1, 1'b1, 25, 1'b0);
        reset_mid_op();
        run(20, 1'b1, 20, 1'b0);
        for (int i = 0; i < 40; i++) begin
            int vl;
            vl = ($urandom_range(3) == 0) ? int'($urandom_range(2047)) : int'($urandom_range(64));
            run(vl, 1'($urandom_range(1)), int'($urandom_range(50)), 1'($urandom_range(1)));
        end
        step();
        step();
        chk("queue_drained", ev_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
